xalu: RTL and testbench
=======================

XALU -- requirements
Module: xalu

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand width and the HI/LO register width.
REQ-002 Parameter MULT_CYCLES, default 5, sets the multiply/multiply-accumulate busy duration in cycles (legal values 1..63).
REQ-003 Parameter DIV_CYCLES, default 10, sets the divide busy duration in cycles (legal values 1..63).
REQ-004 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: high for one cycle to issue the operation on op.
REQ-007 Port op, input, 3 bits, with these encodings:
- 000 MULT, 001 MULTU, 010 DIV, 011 DIVU
- 100 MTHI, 101 MTLO
- 110 MADD, 111 MADDU
REQ-008 Port a, input, WIDTH bits: first operand (rs).
REQ-009 Port b, input, WIDTH bits: second operand (rt).
REQ-010 Port cancel, input, 1 bit: aborts the operation in flight (pipeline flush).
REQ-011 Port busy, output, 1 bit: high while a multi-cycle operation is pending.
REQ-012 Port hi, output, WIDTH bits: the HI register.
REQ-013 Port lo, output, WIDTH bits: the LO register.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, MUL and DIV.
REQ-015 start SHALL be accepted only in IDLE; start while busy=1 SHALL be ignored, because the pause unit stalls D on busy.
REQ-016 Accepting MULT, MULTU, MADD or MADDU SHALL:
- latch the operands;
- enter MUL;
- assert busy from the next cycle for exactly MULT_CYCLES cycles.
REQ-017 Accepting DIV or DIVU SHALL do the same but enter DIV and hold busy for exactly DIV_CYCLES cycles.
REQ-018 MTHI/MTLO SHALL write a into hi/lo at the accepting edge, stay in IDLE and never assert busy.
REQ-019 The down-counter SHALL load N-1 on acceptance and decrement each cycle.
REQ-020 At count 0 the block SHALL write hi/lo, return to IDLE and drop busy at that same edge, so the results are visible in the first cycle busy=0.
REQ-021 MULT/MULTU SHALL compute the full 2*WIDTH-bit product, signed or unsigned respectively, with {hi,lo} = product.
REQ-022 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend; DIVU SHALL be unsigned.
REQ-023 Divide by zero (b=0) SHALL still run DIV_CYCLES and SHALL leave hi/lo unchanged.
REQ-024 Signed overflow (most-negative / -1) SHALL give lo = most-negative and hi = 0.
REQ-025 hi/lo SHALL hold their values between writes.
REQ-026 cancel high in MUL or DIV SHALL:
- return the FSM to IDLE at the next edge;
- clear busy;
- leave hi/lo unchanged.
REQ-027 cancel high in IDLE SHALL have no effect.
REQ-028 If cancel and start are both high in the same cycle, cancel SHALL win and start SHALL be dropped.
REQ-029 A start in the same cycle that busy falls SHALL be ignored; the earliest acceptance is the next cycle.

Reset
REQ-030 reset=0 SHALL immediately force the state to IDLE, busy=0, counter=0, hi=0 and lo=0, including when an operation is in flight.
REQ-031 No hi/lo write SHALL occur from an operation interrupted by reset.

Configuration
REQ-032 Macro XALU_MADD_EN SHALL enable the multiply-accumulate operations.
REQ-033 With XALU_MADD_EN defined, MADD/MADDU SHALL set {hi,lo} = {hi,lo} + a*b (signed or unsigned respectively), modulo 2^(2*WIDTH), using the hi/lo values at completion.
REQ-034 Without XALU_MADD_EN, op 110/111 SHALL be a no-op: not accepted, no busy, hi/lo unchanged.

Verification
REQ-035 MULT, a=32'hFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
REQ-036 DIV, a=-7, b=2 -> busy high 10 cycles; then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). DIVU with the same operands -> lo=32'h7FFFFFFC, hi=1.
REQ-037 MTHI a=5, then MTLO a=9 on the next cycle -> hi=5 and lo=9, each one cycle after its start; busy never rises.
REQ-038 Two cases with hi=lo=1:
- MULTU a=b=32'hFFFFFFFF, cancel at busy cycle 3 -> busy=0 next cycle, hi=lo=1.
- DIV b=0 -> hi=lo=1 after 10 cycles.
REQ-039 Three cases:
- reset=0 mid-DIV -> busy, hi and lo all 0 with no clock edge.
- With XALU_MADD_EN, hi=0, lo=10: MADD a=3, b=4 -> lo=22.
- Without XALU_MADD_EN, the same stimulus -> lo=10 and busy stays 0.

Source files
------------

// File: rtl/xalu.sv
// Multi-cycle HI/LO multiply/divide unit with cancel, MTHI/MTLO and a down-counter busy timer.
// Define XALU_MADD_EN to enable MADD/MADDU (multiply-accumulate into {hi,lo}).
module xalu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t           state_q;
  logic [5:0]       cnt_q;
  logic [5:0]       cnt_d;
  logic             busy_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sign_q;
  logic             acc_q;

  logic             accept;
  logic             op_is_mul;
  logic             op_is_div;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, mul_res;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    accept    = (state_q == IDLE) && start && !cancel;
    op_is_div = (op[2:1] == 2'b01);
    op_is_mul = (op[2:1] == 2'b00);
`ifdef XALU_MADD_EN
    op_is_mul = op_is_mul || (op[2:1] == 2'b11);
`endif
    cnt_d = cnt_q - 6'd1;
  end

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves both flavours.
  always_comb begin
    a_ext = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    b_ext = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod  = a_ext * b_ext;
    mul_res = acc_q ? ({hi_q, lo_q} + prod) : prod;
  end

  // Magnitude division; most-negative / -1 falls out as lo=most-negative, hi=0.
  always_comb begin
    a_neg = sign_q && a_q[WIDTH-1];
    b_neg = sign_q && b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_is_mul || op_is_div) begin
              a_q    <= a;
              b_q    <= b;
              sign_q <= ~op[0];
              acc_q  <= op[2];
              busy_q <= 1'b1;
              state_q <= op_is_mul ? MUL : DIV;
              cnt_q  <= op_is_mul ? 6'(MULT_CYCLES - 1) : 6'(DIV_CYCLES - 1);
            end else if (op == OP_MTHI) begin
              hi_q <= a;
            end else if (op == OP_MTLO) begin
              lo_q <= a;
            end
          end
        end
        MUL, DIV: begin
          if (cancel || cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (!cancel && state_q == MUL) begin
              {hi_q, lo_q} <= mul_res;
            end else if (!cancel && b_q != '0) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_xalu.sv
// Directed-vector bench for xalu: multiply, divide, moves, cancel, reset and MADD.
module tb_xalu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int n;
  logic seen_busy;

  xalu dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drive one start pulse; returns at the negedge right after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(3'b000, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("mult_busy_cycles", 64'(n), 64'd5);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_busy_cycles", 64'(n), 64'd10);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    issue(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("divu_hilo", {hi, lo}, 64'h0000_0001_7FFF_FFFC);

    issue(3'b100, 32'd5, 32'd0);
    check("mthi_hi", {32'd0, hi}, 64'd5);
    seen_busy = busy;
    issue(3'b101, 32'd9, 32'd0);
    check("mtlo_lo", {32'd0, lo}, 64'd9);
    seen_busy = seen_busy | busy;
    check("mt_no_busy", {63'd0, seen_busy}, 64'd0);

    issue(3'b100, 32'd1, 32'd0);
    issue(3'b101, 32'd1, 32'd0);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    @(negedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", {hi, lo}, 64'h0000_0001_0000_0001);

    issue(3'b010, 32'd123, 32'd0);
    wait_done(n);
    check("div0_busy_cycles", 64'(n), 64'd10);
    check("div0_hilo", {hi, lo}, 64'h0000_0001_0000_0001);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // cancel together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 3'b100; a = 32'd42;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_hi", {32'd0, hi}, 64'd0);

    // start while busy is ignored
    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd55;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_start_ignored_cycles", 64'(n), 64'd8);
    check("busy_start_ignored_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // start in the last busy cycle is ignored
    issue(3'b000, 32'd2, 32'd3);
    repeat (4) @(negedge clk);
    check("last_cycle_busy", {63'd0, busy}, 64'd1);
    start = 1'b1; op = 3'b100; a = 32'd77;
    @(negedge clk);
    start = 1'b0;
    check("last_cycle_start_busy", {63'd0, busy}, 64'd0);
    check("last_cycle_start_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // asynchronous reset mid-divide
    issue(3'b100, 32'd3, 32'd0);
    issue(3'b011, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_busy", {63'd0, busy}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_hilo", {hi, lo}, 64'd0);

    issue(3'b101, 32'd10, 32'd0);
    issue(3'b110, 32'd3, 32'd4);
`ifdef XALU_MADD_EN
    wait_done(n);
    check("madd_busy_cycles", 64'(n), 64'd5);
    check("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0016);
`else
    seen_busy = busy;
    repeat (6) begin
      @(negedge clk);
      seen_busy = seen_busy | busy;
    end
    check("madd_off_busy", {63'd0, seen_busy}, 64'd0);
    check("madd_off_hilo", {hi, lo}, 64'h0000_0000_0000_000A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
